// File: rtl/xmos_slice_gpio_bank_if.sv
// Serial configuration link between the XMOS tile and one GPIO bank.
interface xmos_slice_gpio_bank_if;
    // Handshake: the tile owns the frame. cs_n low frames a transfer, mosi is
    // valid on every sclk rise, miso is updated on every sclk fall, and the bank
    // has no way to stall the tile (there is no ready), so it must keep up at
    // sclk <= CLK/6.
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs_n, output mosi, input miso);
    modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/xmos_slice_gpio_bank.sv
// Run-time configurable GPIO bank for the XMOS CPLD slice. Direction, output
// level and interrupt enables are loaded over an oversampled SPI mode 0 link;
// every change on a synchronised pad sets a sticky EDGE flag.
module xmos_slice_gpio_bank #(
    parameter int NCH         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    xmos_slice_gpio_bank_if.slave spi,
    output logic                  irq,
    inout  wire  [NCH-1:0]        pad
);
    typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

    localparam logic [5:0] LAST_HDR  = 6'd7;
    localparam logic [5:0] LAST_DATA = 6'(NCH - 1);
    localparam logic [2:0] A_DIR     = 3'd0;
    localparam logic [2:0] A_OUT     = 3'd1;
    localparam logic [2:0] A_IN      = 3'd2;
    localparam logic [2:0] A_EDGE    = 3'd3;
    localparam logic [2:0] A_IEN     = 3'd4;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_s, cs_s, mosi_s, sclk_d, cs_d;
    logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [NCH-1:0] pad_sync [SYNC_STAGES];
    logic [NCH-1:0] sync_in, sync_in_d;
    logic [NCH-1:0] dir_q, out_q, edge_q, ien_q;

    // hdr_q keeps only {rnw, addr}; the four reserved header bits are not stored.
    logic [5:0]     bit_cnt;
    logic [3:0]     hdr_q;
    logic           rnw_q;
    logic [2:0]     addr_q;
    logic [NCH-1:0] rx_q, tx_q, clr_mask_q, rd_data;
    logic           commit_q;
    logic           hdr_done, data_done;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign sync_in   = pad_sync[SYNC_STAGES-1];

    assign hdr_done  = (state == HDR)  && !cs_rise && sclk_rise && (bit_cnt == LAST_HDR);
    assign data_done = (state == DATA) && !cs_rise && sclk_rise && (bit_cnt == LAST_DATA);

    // Synchronise the serial link and keep one delayed copy for edge detection.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    // Synchronise the pads; sync_in_d gives the previous sample for change detection.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int s = 0; s < SYNC_STAGES; s++) pad_sync[s] <= '0;
            sync_in_d <= '0;
        end else begin
            pad_sync[0] <= pad;
            for (int s = 1; s < SYNC_STAGES; s++) pad_sync[s] <= pad_sync[s-1];
            sync_in_d <= sync_in;
        end
    end

    // Frame state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_next;
    end

    // Frame sequencing: cs_n rising outside DONE aborts without committing.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (cs_fall) state_next = HDR;
            HDR: begin
                if (cs_rise)       state_next = IDLE;
                else if (hdr_done) state_next = DATA;
            end
            DATA: begin
                if (cs_rise)        state_next = IDLE;
                else if (data_done) state_next = DONE;
            end
            DONE: if (cs_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Register read mux, addressed by the header bits being completed this cycle.
    always_comb begin
        rd_data = '0;
        case (hdr_q[2:0])
            A_DIR:   rd_data = dir_q;
            A_OUT:   rd_data = out_q;
            A_IN:    rd_data = sync_in;
            A_EDGE:  rd_data = edge_q;
            A_IEN:   rd_data = ien_q;
            default: rd_data = '0;
        endcase
    end

    // Header/data shifting, read snapshot and the one-cycle commit strobe.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bit_cnt    <= '0;
            hdr_q      <= '0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            clr_mask_q <= '0;
            commit_q   <= 1'b0;
        end else begin
            commit_q <= data_done;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    hdr_q   <= '0;
                end
                HDR: begin
                    if (sclk_rise && !cs_rise) begin
                        if (bit_cnt < 6'd4) hdr_q <= {hdr_q[2:0], mosi_s};
                        if (bit_cnt == LAST_HDR) begin
                            bit_cnt    <= '0;
                            rnw_q      <= hdr_q[3];
                            addr_q     <= hdr_q[2:0];
                            tx_q       <= hdr_q[3] ? rd_data : '0;
                            clr_mask_q <= (hdr_q[3] && hdr_q[2:0] == A_EDGE) ? edge_q : '0;
                        end else begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                    end
                end
                DATA: begin
                    if (!cs_rise) begin
                        if (sclk_rise) begin
                            rx_q    <= (rx_q << 1) | NCH'(mosi_s);
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                        if (sclk_fall && rnw_q) tx_q <= tx_q << 1;
                    end
                end
                default: ;
            endcase
        end
    end

    // miso presents the next read bit on each sclk fall and is 0 outside DATA.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                                         spi.miso <= 1'b0;
        else if (state_next != DATA)                       spi.miso <= 1'b0;
        else if (state == DATA && sclk_fall && rnw_q)      spi.miso <= tx_q[NCH-1];
    end

    // Configuration registers and sticky edge flags; a new edge beats a read-clear.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dir_q  <= '0;
            out_q  <= '0;
            ien_q  <= '0;
            edge_q <= '0;
        end else begin
            if (commit_q && !rnw_q) begin
                case (addr_q)
                    A_DIR:   dir_q <= rx_q;
                    A_OUT:   out_q <= rx_q;
                    A_IEN:   ien_q <= rx_q;
                    default: ;
                endcase
            end
            edge_q <= (edge_q & ~((commit_q && rnw_q) ? clr_mask_q : '0)) | (sync_in ^ sync_in_d);
        end
    end

    // Registered interrupt from enabled edge flags.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) irq <= 1'b0;
        else       irq <= |(edge_q & ien_q);
    end

    for (genvar i = 0; i < NCH; i++) begin : g_pad
        assign pad[i] = dir_q[i] ? out_q[i] : 1'bz;
    end
endmodule

// File: tb/tb_xmos_slice_gpio_bank.sv
// Directed plus randomised bench for two GPIO banks (16 pads / 2 sync stages and
// 8 pads / 3 sync stages) sharing one serial bus with separate chip selects.
`timescale 1ns/1ps
module tb_xmos_slice_gpio_bank;
    localparam int HALF = 6;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    logic sclk = 1'b0, mosi = 1'b0, cs0_n = 1'b1, cs1_n = 1'b1;
    logic irq0, irq1;
    wire [15:0] pad0;
    wire [7:0]  pad1;
    logic [31:0] ext_val [2];
    logic [31:0] ext_en  [2];

    // Reference model of each bank, in register terms.
    logic [31:0] dir_m [2], out_m [2], ien_m [2], edge_m [2], lvl_m [2];
    int checks = 0;
    int errors = 0;

    xmos_slice_gpio_bank_if spi0 ();
    xmos_slice_gpio_bank_if spi1 ();
    assign spi0.sclk = sclk;
    assign spi0.mosi = mosi;
    assign spi0.cs_n = cs0_n;
    assign spi1.sclk = sclk;
    assign spi1.mosi = mosi;
    assign spi1.cs_n = cs1_n;

    xmos_slice_gpio_bank #(.NCH(16), .SYNC_STAGES(2)) dut0 (
        .CLK(CLK), .nRST(nRST), .spi(spi0), .irq(irq0), .pad(pad0));
    xmos_slice_gpio_bank #(.NCH(8), .SYNC_STAGES(3)) dut1 (
        .CLK(CLK), .nRST(nRST), .spi(spi1), .irq(irq1), .pad(pad1));

    for (genvar g = 0; g < 16; g++) begin : g_p0
        assign pad0[g] = ext_en[0][g] ? ext_val[0][g] : 1'bz;
    end
    for (genvar g = 0; g < 8; g++) begin : g_p1
        assign pad1[g] = ext_en[1][g] ? ext_val[1][g] : 1'bz;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] msk(input int sel);
        return sel ? 32'hFF : 32'hFFFF;
    endfunction
    function automatic int nch(input int sel);
        return sel ? 8 : 16;
    endfunction
    function automatic int sync_of(input int sel);
        return sel ? 3 : 2;
    endfunction
    function automatic logic miso_of(input int sel);
        return sel ? spi1.miso : spi0.miso;
    endfunction
    function automatic logic irq_of(input int sel);
        return sel ? irq1 : irq0;
    endfunction
    function automatic logic [31:0] pad_of(input int sel);
        return sel ? {24'b0, pad1} : {16'b0, pad0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_cs(input int sel, input logic v);
        if (sel != 0) cs1_n = v;
        else          cs0_n = v;
    endtask

    // Pad level follows from who drives it; any level change is an edge.
    task automatic apply(input int sel);
        logic [31:0] nw;
        nw = ((dir_m[sel] & out_m[sel]) | (~dir_m[sel] & ext_val[sel])) & msk(sel);
        edge_m[sel] = edge_m[sel] | (nw ^ lvl_m[sel]);
        lvl_m[sel] = nw;
    endtask

    task automatic model_write(input int sel, input logic [2:0] addr, input logic [31:0] data);
        case (addr)
            3'd0: dir_m[sel] = data & msk(sel);
            3'd1: out_m[sel] = data & msk(sel);
            3'd4: ien_m[sel] = data & msk(sel);
            default: ;
        endcase
        apply(sel);
    endtask

    function automatic logic [31:0] model_read(input int sel, input logic [2:0] addr);
        case (addr)
            3'd0:    return dir_m[sel];
            3'd1:    return out_m[sel];
            3'd2:    return lvl_m[sel];
            3'd3:    return edge_m[sel];
            3'd4:    return ien_m[sel];
            default: return 32'h0;
        endcase
    endfunction

    task automatic end_cs(input int sel);
        sclk = 1'b0;
        tick(HALF);
        set_cs(sel, 1'b1);
        tick(HALF);
    endtask

    // Sends a frame MSB first; with cut >= 0 it stops before bit 'cut' leaving cs_n low.
    task automatic frame(input int sel, input logic rnw, input logic [2:0] addr,
                         input logic [31:0] data, input int cut, output logic [31:0] rd);
        logic [7:0] hdr;
        int n;
        hdr = {rnw, addr, 4'b0000};
        n = nch(sel);
        rd = '0;
        set_cs(sel, 1'b0);
        tick(HALF);
        for (int i = 0; i < 8 + n; i++) begin
            if (i == cut) return;
            sclk = 1'b0;
            mosi = (i < 8) ? hdr[7-i] : data[n-1-(i-8)];
            tick(HALF);
            if (i >= 8) rd = {rd[30:0], miso_of(sel)};
            sclk = 1'b1;
            tick(HALF);
        end
        end_cs(sel);
    endtask

    task automatic xfer(input int sel, input logic rnw, input logic [2:0] addr,
                        input logic [31:0] data, input string tag);
        logic [31:0] exp, rd;
        exp = model_read(sel, addr);
        frame(sel, rnw, addr, data, -1, rd);
        if (rnw) begin
            check(tag, rd, exp);
            if (addr == 3'd3) edge_m[sel] = edge_m[sel] & ~exp;
        end else begin
            model_write(sel, addr, data);
        end
        check({tag, "_miso_idle"}, {31'b0, miso_of(sel)}, 32'h0);
    endtask

    // Write whose last sclk rise is timed, counting CLKs until the pads show 'want'.
    task automatic timed_write(input int sel, input logic [2:0] addr, input logic [31:0] data,
                               input logic [31:0] mask, input logic [31:0] want, output int k);
        logic [31:0] rd;
        frame(sel, 1'b0, addr, data, 8 + nch(sel) - 1, rd);
        sclk = 1'b0;
        mosi = data[0];
        tick(HALF);
        sclk = 1'b1;
        k = 0;
        while (k < 30 && (pad_of(sel) & mask) !== want) begin
            tick(1);
            k++;
        end
        tick(HALF);
        end_cs(sel);
        model_write(sel, addr, data);
    endtask

    task automatic wait_irq(input int sel, output int k);
        k = 0;
        while (k < 30 && irq_of(sel) !== 1'b1) begin
            tick(1);
            k++;
        end
    endtask

    initial begin
        logic [31:0] rd, exp, r;
        int k;
        for (int s = 0; s < 2; s++) begin
            dir_m[s] = '0; out_m[s] = '0; ien_m[s] = '0; edge_m[s] = '0; lvl_m[s] = '0;
            ext_val[s] = '0;
            ext_en[s] = msk(s);
        end
        tick(5);
        nRST = 1'b1;
        tick(5);

        check("rst_miso0", {31'b0, spi0.miso}, 32'h0);
        check("rst_irq0", {31'b0, irq0}, 32'h0);
        check("rst_miso1", {31'b0, spi1.miso}, 32'h0);
        check("rst_irq1", {31'b0, irq1}, 32'h0);
        xfer(0, 1'b1, 3'd0, 0, "rd_dir_rst");

        // Lower byte becomes output; the bench releases those pads after commit.
        xfer(0, 1'b0, 3'd0, 32'h00FF, "wr_dir");
        ext_en[0] = 32'hFF00;
        timed_write(0, 3'd1, 32'h00A5, 32'hFF, 32'hA5, k);
        check("out_latency", k, sync_of(0) + 2);
        check("pad_lo", pad_of(0) & 32'hFF, 32'hA5);

        ext_val[0][15:8] = 8'h3C;
        apply(0);
        tick(10);
        xfer(0, 1'b1, 3'd2, 0, "rd_in");
        xfer(0, 1'b1, 3'd3, 0, "rd_edge");
        xfer(0, 1'b1, 3'd3, 0, "rd_edge_cleared");

        // Interrupt on pad 8.
        xfer(0, 1'b0, 3'd4, 32'h0100, "wr_ien");
        check("irq_quiet", {31'b0, irq0}, 32'h0);
        ext_val[0][8] = ~ext_val[0][8];
        apply(0);
        wait_irq(0, k);
        check("irq_latency", k, sync_of(0) + 2);
        xfer(0, 1'b1, 3'd3, 0, "rd_edge_irq");
        tick(3);
        check("irq_cleared", {31'b0, irq0}, {31'b0, |(edge_m[0] & ien_m[0])});

        // Pad 8 edge lands in the same cycle as the read-clear: set wins.
        ext_val[0][8] = ~ext_val[0][8];
        apply(0);
        tick(10);
        exp = model_read(0, 3'd3);
        frame(0, 1'b1, 3'd3, 0, 23, rd);
        sclk = 1'b0;
        mosi = 1'b0;
        tick(HALF);
        rd = {rd[30:0], spi0.miso};
        sclk = 1'b1;
        tick(1);
        ext_val[0][8] = ~ext_val[0][8];
        edge_m[0] = edge_m[0] & ~exp;
        apply(0);
        tick(HALF);
        end_cs(0);
        check("rd_edge_race", rd, exp);
        tick(3);
        check("irq_race", {31'b0, irq0}, {31'b0, |(edge_m[0] & ien_m[0])});
        xfer(0, 1'b1, 3'd3, 0, "rd_edge_after_race");

        // Aborted write and aborted EDGE read leave state untouched.
        frame(0, 1'b0, 3'd1, 32'hFFFF, 12, rd);
        end_cs(0);
        xfer(0, 1'b1, 3'd1, 0, "rd_out_abort");
        ext_val[0][9] = ~ext_val[0][9];
        apply(0);
        tick(10);
        frame(0, 1'b1, 3'd3, 0, 12, rd);
        end_cs(0);
        check("miso_abort", {31'b0, spi0.miso}, 32'h0);
        xfer(0, 1'b1, 3'd3, 0, "rd_edge_abort");

        // Unused addresses.
        xfer(0, 1'b0, 3'd6, 32'h1234, "wr_a6");
        xfer(0, 1'b1, 3'd6, 0, "rd_a6");
        xfer(0, 1'b1, 3'd5, 0, "rd_a5");
        xfer(0, 1'b1, 3'd4, 0, "rd_ien_keep");
        xfer(0, 1'b1, 3'd0, 0, "rd_dir_keep");

        // Randomised output levels, input levels and enables.
        for (int it = 0; it < 6; it++) begin
            r = $urandom;
            xfer(0, 1'b0, 3'd1, r & 32'hFFFF, "wr_out_rnd");
            ext_val[0][15:8] = r[31:24];
            apply(0);
            xfer(0, 1'b0, 3'd4, $urandom_range(0, 65535), "wr_ien_rnd");
            tick(10);
            check("irq_rnd", {31'b0, irq0}, {31'b0, |(edge_m[0] & ien_m[0])});
            xfer(0, 1'b1, 3'd2, 0, "rd_in_rnd");
            xfer(0, 1'b1, 3'd3, 0, "rd_edge_rnd");
            tick(4);
            check("irq_rnd_clr", {31'b0, irq0}, {31'b0, |(edge_m[0] & ien_m[0])});
        end

        // Reset in the middle of a frame.
        xfer(0, 1'b0, 3'd4, 32'hFFFF, "wr_ien_all");
        ext_val[0][9] = ~ext_val[0][9];
        apply(0);
        tick(10);
        check("irq_pre_rst", {31'b0, irq0}, 32'h1);
        ext_val[0] = lvl_m[0];
        ext_en[0] = 32'hFFFF;
        frame(0, 1'b0, 3'd0, 32'hFFFF, 20, rd);
        nRST = 1'b0;
        tick(2);
        check("rst_mid_irq", {31'b0, irq0}, 32'h0);
        check("rst_mid_miso", {31'b0, spi0.miso}, 32'h0);
        nRST = 1'b1;
        end_cs(0);
        dir_m[0] = '0; out_m[0] = '0; ien_m[0] = '0;
        edge_m[0] = lvl_m[0];
        xfer(0, 1'b1, 3'd0, 0, "rd_dir_post_rst");
        xfer(0, 1'b1, 3'd1, 0, "rd_out_post_rst");
        xfer(0, 1'b0, 3'd4, 32'h1234, "wr_ien_post_rst");
        xfer(0, 1'b1, 3'd4, 0, "rd_ien_post_rst");

        // Eight-pad bank with three synchroniser stages.
        xfer(1, 1'b0, 3'd0, 32'h0F, "b1_wr_dir");
        ext_en[1] = 32'hF0;
        timed_write(1, 3'd1, 32'h05, 32'h0F, 32'h05, k);
        check("b1_out_latency", k, sync_of(1) + 2);
        ext_val[1][7:4] = 4'hA;
        apply(1);
        tick(10);
        xfer(1, 1'b1, 3'd2, 0, "b1_rd_in");
        xfer(1, 1'b1, 3'd3, 0, "b1_rd_edge");
        xfer(1, 1'b0, 3'd6, 32'hFF, "b1_wr_a6");
        xfer(1, 1'b1, 3'd6, 0, "b1_rd_a6");
        xfer(1, 1'b1, 3'd1, 0, "b1_rd_out");
        xfer(1, 1'b0, 3'd4, 32'h80, "b1_wr_ien");
        ext_val[1][7] = ~ext_val[1][7];
        apply(1);
        wait_irq(1, k);
        check("b1_irq_latency", k, sync_of(1) + 2);
        xfer(1, 1'b1, 3'd3, 0, "b1_rd_edge_irq");
        tick(4);
        check("b1_irq_cleared", {31'b0, irq1}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
